// File: rtl/csa_resolver_pkg.sv
// Shared definitions for the carry-save resolver.
// Holds the FSM state encoding and the default operand and slice widths.
package csa_resolver_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int unsigned DEF_WIDTH = 16;
   localparam int unsigned DEF_CHUNK = 4;

endpackage

// File: rtl/csa_resolver_chunk_add.sv
// One CHUNK-bit slice adder: a + b + cin -> CHUNK-bit sum and carry-out.
// Ports:
//   a, b  : slice operands
//   cin   : incoming running carry
//   sum   : slice sum
//   cout  : slice carry-out
module csa_chunk_add #(
   parameter int unsigned CHUNK = 4
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             cin,
   output logic [CHUNK-1:0] sum,
   output logic             cout
);

   logic [CHUNK:0] total;

   always_comb begin
      total = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
      sum   = total[CHUNK-1:0];
      cout  = total[CHUNK];
   end

endmodule

// File: rtl/csa_resolver.sv
// Resolves a carry-save pair (sum, carry) into a binary value
// sum + (carry << 1), CHUNK bits per clock, LSB slice first.
// Ports:
//   clk, rst              : clock, asynchronous active-high reset
//   in_valid/in_ready     : operand handshake (accepted only in IDLE)
//   in_sum, in_carry      : redundant operand pair
//   out_valid/out_ready   : result handshake (result held while stalled)
//   result                : WIDTH+2-bit resolved value
module csa_resolver
   import csa_resolver_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH,
   parameter int unsigned CHUNK = DEF_CHUNK
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_sum,
   input  logic [WIDTH-1:0] in_carry,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH+1:0] result
);

   localparam int unsigned NCHUNK = WIDTH / CHUNK;
   localparam int unsigned IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

   state_t             state;
   logic [WIDTH-1:0]   sum_q;
   logic [WIDTH-1:0]   csh_q;    // carry vector pre-shifted by one, truncated
   logic               ctop_q;   // carry bit shifted out of csh_q
   logic [IDX_W-1:0]   idx;
   logic               run_c;

   logic [CHUNK-1:0]   slice_a;
   logic [CHUNK-1:0]   slice_b;
   logic [CHUNK-1:0]   slice_sum;
   logic               slice_cout;

   always_comb begin
      slice_a = sum_q[int'(idx)*CHUNK +: CHUNK];
      slice_b = csh_q[int'(idx)*CHUNK +: CHUNK];
   end

   csa_chunk_add #(
      .CHUNK (CHUNK)
   ) u_chunk_add (
      .a    (slice_a),
      .b    (slice_b),
      .cin  (run_c),
      .sum  (slice_sum),
      .cout (slice_cout)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         result    <= '0;
         idx       <= '0;
         run_c     <= 1'b0;
         sum_q     <= '0;
         csh_q     <= '0;
         ctop_q    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  sum_q    <= in_sum;
                  csh_q    <= WIDTH'({in_carry, 1'b0});
                  ctop_q   <= in_carry[WIDTH-1];
                  idx      <= '0;
                  run_c    <= 1'b0;
                  in_ready <= 1'b0;
                  state    <= RUN;
               end
            end
            RUN: begin
               result[int'(idx)*CHUNK +: CHUNK] <= slice_sum;
               run_c <= slice_cout;
               if (idx == LAST_IDX) begin
                  // Top two bits: the bit shifted out of the carry vector
                  // plus the carry out of the last slice.
                  result[WIDTH+1:WIDTH] <= {1'b0, ctop_q} + {1'b0, slice_cout};
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_csa_resolver.sv
module tb_csa_resolver;

   localparam int unsigned W = 16;

   logic          clk;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_sum;
   logic [W-1:0]  in_carry;
   logic          out_valid;
   logic          out_ready;
   logic [W+1:0]  result;

   int checks = 0;
   int errors = 0;

   logic [W+1:0] exp_q[$];

   typedef struct {
      string        name;
      logic [W-1:0] sum;
      logic [W-1:0] carry;
      logic [W+1:0] exp;
   } vec_t;

   vec_t vecs[6];

   csa_resolver #(
      .WIDTH (16),
      .CHUNK (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_sum    (in_sum),
      .in_carry  (in_carry),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [W+1:0] model(input logic [W-1:0] s, input logic [W-1:0] c);
      return {2'b00, s} + {1'b0, c, 1'b0};
   endfunction

   // Accept one pair, scramble inputs during RUN, verify latency and result,
   // then release the result and confirm return to IDLE.
   task automatic run_txn(input string name, input logic [W-1:0] s,
                          input logic [W-1:0] c, input logic [W+1:0] exp);
      int lat;
      logic [W+1:0] want;
      check({name, "_ready"}, 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      in_sum   = s;
      in_carry = c;
      exp_q.push_back(exp);
      step();
      lat = 0;
      while (!out_valid && lat < 20) begin
         check({name, "_run_rdy"}, 32'(in_ready), 32'd0);
         in_valid  = 1'b1;
         in_sum    = W'($urandom);
         in_carry  = W'($urandom);
         out_ready = 1'b1;
         step();
         lat++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      check({name, "_latency"}, 32'(lat), 32'd4);
      want = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
      check({name, "_result"}, 32'(result), 32'(want));
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check({name, "_idle"}, 32'({in_ready, out_valid}), 32'b10);
   endtask

   initial begin
      vecs[0] = '{"zero",  16'h0000, 16'h0000, 18'h00000};
      vecs[1] = '{"ripple",16'hFFFF, 16'h0001, 18'h10001};
      vecs[2] = '{"max",   16'hFFFF, 16'hFFFF, 18'h2FFFD};
      vecs[3] = '{"mix",   16'h1234, 16'h0101, 18'h01436};
      vecs[4] = '{"topc",  16'h8000, 16'h8000, 18'h18000};
      vecs[5] = '{"fill",  16'h0F0F, 16'h7878, 18'h0FFFF};

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      in_sum = '0; in_carry = '0;
      #1;
      check("reset_in_ready", 32'(in_ready), 32'd1);
      check("reset_out_valid", 32'(out_valid), 32'd0);
      check("reset_result", 32'(result), 32'd0);
      step(); step();
      rst = 1'b0;

      for (int i = 0; i < 6; i++)
         run_txn(vecs[i].name, vecs[i].sum, vecs[i].carry, vecs[i].exp);

      // Stall in DONE: result and handshakes must hold.
      begin
         int lat;
         in_valid = 1'b1; in_sum = 16'h1234; in_carry = 16'h0101;
         step();
         in_valid = 1'b0;
         lat = 0;
         while (!out_valid && lat < 20) begin step(); lat++; end
         check("stall_latency", 32'(lat), 32'd4);
         for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            step();
            check("stall_result", 32'(result), 32'h01436);
            check("stall_hs", 32'({in_ready, out_valid}), 32'b01);
         end
         in_valid = 1'b0;
         out_ready = 1'b1;
         step();
         out_ready = 1'b0;
         check("stall_release", 32'({in_ready, out_valid}), 32'b10);
      end

      // Asynchronous reset during the second RUN clock aborts the operation.
      in_valid = 1'b1; in_sum = 16'hAAAA; in_carry = 16'h5555;
      step();
      in_valid = 1'b0;
      step();
      #2 rst = 1'b1;
      #1;
      check("abort_out_valid", 32'(out_valid), 32'd0);
      check("abort_result", 32'(result), 32'd0);
      check("abort_in_ready", 32'(in_ready), 32'd1);
      step();
      rst = 1'b0;
      run_txn("post_reset", 16'h0003, 16'h0002, 18'h00007);

      // Random stream with random downstream stalls.
      begin
         int sent = 0;
         int got = 0;
         int cyc = 0;
         logic fire_in, fire_out;
         logic [W+1:0] want;
         while (got < 100 && cyc < 5000) begin
            if (!in_valid && sent < 100 && $urandom_range(0, 3) != 0) begin
               in_valid = 1'b1;
               in_sum   = W'($urandom);
               in_carry = W'($urandom);
            end
            out_ready = 1'($urandom_range(0, 1));
            fire_in  = in_valid && in_ready;
            fire_out = out_valid && out_ready;
            if (fire_in) begin
               exp_q.push_back(model(in_sum, in_carry));
               sent++;
            end
            if (fire_out) begin
               want = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
               check("stream_result", 32'(result), 32'(want));
               got++;
            end
            step();
            if (fire_in) in_valid = 1'b0;
            cyc++;
         end
         in_valid = 1'b0;
         out_ready = 1'b0;
         check("stream_count", 32'(got), 32'd100);
         check("stream_leftover", 32'(exp_q.size()), 32'd0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
